// File: rtl/spram_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | spram_mem_ctrl : byte-write single-port RAM with valid/ready handshake,     |
// |                  optional output register and post-reset clear sequencer.   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module spram_mem_ctrl #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 16384,
  parameter int                ADDR_W    = 14,
  parameter int                REG_OUT   = 0,
  parameter int                CLEAR_EN  = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                init_busy
);

  localparam int                c_nb   = DATA_W / 8;
  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   c_dep  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_RESP  = 2'd2,
    S_PIPE  = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic                r_busy;
  logic [DATA_W-1:0]   r_cap;

  logic                w_req;
  logic                w_in_range;
  logic [DATA_W-1:0]   w_rd_word;
  logic [DATA_W-1:0]   w_merged;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_din;

  assign w_req      = (r_state == S_IDLE) && mem_valid;
  assign w_in_range = ({1'b0, mem_addr} < c_dep);
  assign w_rd_word  = r_mem[mem_addr];

  // Byte-lane merge of new data over the currently stored word
  for (genvar i = 0; i < c_nb; i++) begin : g_lane
    assign w_merged[8*i +: 8] = mem_wstrb[i] ? mem_wdata[8*i +: 8] : w_rd_word[8*i +: 8];
  end

  assign w_mem_we   = (r_state == S_CLEAR) || (w_req && w_in_range && (|mem_wstrb));
  assign w_mem_addr = (r_state == S_CLEAR) ? r_clr_cnt : mem_addr;
  assign w_mem_din  = (r_state == S_CLEAR) ? CLEAR_VAL : w_merged;

  // Array has no reset; writes are suppressed while reset is held
  always_ff @(posedge clk) begin
    if (resetn && w_mem_we) r_mem[w_mem_addr] <= w_mem_din;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= (CLEAR_EN != 0) ? S_CLEAR : S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (r_clr_cnt == c_last) w_state_nxt = S_IDLE;
      S_IDLE:  if (mem_valid) w_state_nxt = (REG_OUT != 0) ? S_PIPE : S_RESP;
      S_PIPE:  w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_clr_cnt <= '0;
      r_busy    <= 1'b1;
      r_cap     <= '0;
    end else begin
      if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
      r_busy <= (w_state_nxt == S_CLEAR);
      // Read-before-write capture; out-of-range requests return zero
      if (w_req) r_cap <= w_in_range ? w_rd_word : '0;
    end
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic [DATA_W-1:0] r_rdata;
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                 r_rdata <= '0;
      else if (r_state == S_PIPE)  r_rdata <= r_cap;
    end
    assign mem_rdata = r_rdata;
  end else begin : g_no_reg
    assign mem_rdata = r_cap;
  end

  assign mem_ready = (r_state == S_RESP);
  assign init_busy = r_busy;

endmodule
`default_nettype wire

// File: doc/spram_mem_ctrl.md
Name: spram_mem_ctrl

Overview:
- Parametrised successor to the fixed 32-bit x 16K byte-write SPRAM used as PicoSoC main memory.
- Generic data width and depth.
- Adds a native PicoRV32 valid/ready handshake, an optional output register stage, a post-reset hardware clear sequencer and out-of-range address handling.
- Sits between the PicoSoC memory bus decoder and on-chip block RAM.
- Serves as main RAM and as the AES coprocessor's key/data scratch store.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 16384, number of words; need not be a power of two.
- ADDR_W, 14, word-address width; must satisfy 2**ADDR_W >= DEPTH.
- REG_OUT, 0, 1 adds one output register stage (read latency 2 instead of 1).
- CLEAR_EN, 1, 1 runs the zero-fill sequencer after reset release.
- CLEAR_VAL, 0, DATA_W-bit value written to every word during clear.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- resetn, input, 1, asynchronous active-low reset.
- mem_valid, input, 1, request valid; held by the master until mem_ready.
- mem_ready, output, 1, single-cycle acknowledge.
- mem_addr, input, ADDR_W, word address.
- mem_wstrb, input, DATA_W/8, byte write enables; all zero means read.
- mem_wdata, input, DATA_W, write data.
- mem_rdata, output, DATA_W, read data; valid while mem_ready=1.
- init_busy, output, 1, high while in reset or while the clear sequence runs.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on resetn. Assertion takes effect immediately, independent of clk; deassertion is synchronised by the SoC reset block.
- Reset values:
  - mem_ready=0, mem_rdata=0.
  - init_busy=1.
  - FSM=CLEAR if CLEAR_EN=1, otherwise IDLE with init_busy=0 from the first clock after reset release.
  - Clear counter=0.
  - Array contents are not reset.
- FSM states: CLEAR, IDLE, RESP, PIPE (PIPE only when REG_OUT=1).
- CLEAR:
  - Each cycle writes CLEAR_VAL to word clr_cnt, then increments clr_cnt.
  - After writing word DEPTH-1, the next state is IDLE and init_busy drops to 0 in the same edge.
  - The sequence takes exactly DEPTH cycles.
  - mem_valid is ignored: no ack, no write.
  - A reset during CLEAR restarts the sequence from word 0.
- IDLE, mem_valid=0: stay in IDLE.
- IDLE, mem_valid=1, in-range address (mem_addr < DEPTH):
  - Each byte lane i with mem_wstrb[i]=1 takes mem_wdata[8i+7:8i] at this edge; other lanes are unchanged.
  - The array read of mem_addr is captured at the same edge (read-before-write: old data).
  - Next state is RESP (REG_OUT=0) or PIPE (REG_OUT=1).
- IDLE, mem_valid=1, out-of-range address (mem_addr >= DEPTH): no array access, response data forced to 0, same timing as in-range.
- PIPE: moves captured data to the output register. Next state is RESP.
- RESP:
  - mem_ready=1 for exactly one cycle.
  - For reads, mem_rdata is the stored word.
  - For writes, mem_rdata is the pre-write word (masters must ignore it).
  - Next state is IDLE.
- Latency, measured from the edge at which IDLE samples mem_valid to the mem_ready cycle: 1 cycle (REG_OUT=0) or 2 cycles (REG_OUT=1).
- Back-to-back requests: minimum spacing is 2 cycles (REG_OUT=0) or 3 cycles (REG_OUT=1). mem_valid high in the IDLE cycle after RESP is a new request.
- Inputs are sampled only in IDLE. Changes to mem_addr, mem_wstrb or mem_wdata during PIPE or RESP are ignored.
- mem_rdata holds its last value outside RESP, except that reset clears it to 0.
- Single port: no concurrent read and write to different addresses.

Test Plan:
- Clear sequence: CLEAR_EN=1, DEPTH=16, CLEAR_VAL=32'hA5A5A5A5, release reset -> init_busy high for exactly 16 cycles. mem_valid asserted during clear gets no mem_ready until init_busy=0. Subsequent reads of words 0 and 15 return 32'hA5A5A5A5.
- Byte strobes: write 32'h11223344 to addr 5 with wstrb=4'hF, then 32'hAABBCCDD with wstrb=4'b0101 -> read of addr 5 returns 32'h11BB33DD.
- Latency: REG_OUT=0 read -> mem_ready exactly 1 cycle after the sampling edge. REG_OUT=1 -> 2 cycles. mem_ready is a single-cycle pulse in both cases.
- Out of range: DEPTH=12, write 32'hFFFFFFFF to addr 12, then read addr 12 and addr 0 -> mem_ready still pulses. Read of addr 12 returns 0. Addr 0 is unchanged.
- Reset mid-operation:
  - Assert resetn=0 mid-CLEAR at clr_cnt=7 -> mem_ready=0 and init_busy=1 immediately, without waiting for a clock edge. After release, clear restarts and lasts a full DEPTH cycles.
  - Assert reset between request and RESP -> no mem_ready is issued.
- Back-to-back: DATA_W=64, REG_OUT=0, read, write, read to the same address with mem_valid held continuously -> three acks spaced 2 cycles apart. The final read returns the written 64-bit value.
